// File: rtl/multi_lane_pipelined_adder.sv
// -----------------------------------------------------------------------------
// multi_lane_pipelined_adder
//
// Adds or subtracts LANES independent WIDTH-bit operand pairs per transfer.
// Each lane is a ripple carry chain cut into SEG-bit segments, with one
// register stage per segment (STAGES = ceil(WIDTH/SEG)). The whole pipeline
// advances together when the output slot is empty or being drained.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operand set presented
//   in_ready   block accepts the operand set this cycle
//   sub        0 = add, 1 = subtract (all lanes), sampled with operands
//   a, b       lane k operand at bits [k*WIDTH +: WIDTH]
//   cin        per-lane carry-in (ignored when sub = 1)
//   out_valid  result available
//   out_ready  sink accepts the result
//   sum        per-lane result, same packing as a
//   cout       per-lane carry-out; in subtract mode 1 = no borrow
//
// Optional feature, enabled by defining MLPA_OVF_STICKY_EN:
//   ovf        per-lane signed overflow of the presented result
//   ovf_sticky per-lane sticky overflow, set on output transfers
//   ovf_clr    clears ovf_sticky on the next edge (a set wins over the clear)
// -----------------------------------------------------------------------------
module multi_lane_pipelined_adder #(
    parameter int WIDTH = 8,
    parameter int LANES = 4,
    parameter int SEG   = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   sub,
    input  logic [LANES*WIDTH-1:0] a,
    input  logic [LANES*WIDTH-1:0] b,
    input  logic [LANES-1:0]       cin,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*WIDTH-1:0] sum,
    output logic [LANES-1:0]       cout
`ifdef MLPA_OVF_STICKY_EN
    ,
    input  logic                   ovf_clr,
    output logic [LANES-1:0]       ovf,
    output logic [LANES-1:0]       ovf_sticky
`endif
);

    localparam int STAGES = (WIDTH + SEG - 1) / SEG;
    localparam int LW     = LANES * WIDTH;
    localparam int LAST   = STAGES - 1;

    // Per-stage pipeline registers. Operand b is stored already conditioned
    // (inverted in subtract mode) so later stages need no knowledge of sub.
    logic          vld_q [STAGES];
    logic [LW-1:0] a_q   [STAGES];
    logic [LW-1:0] b_q   [STAGES];
    logic [LW-1:0] sum_q [STAGES];
    logic [LANES-1:0] c_q [STAGES];

    logic adv;

    assign adv       = !vld_q[LAST] || out_ready;
    assign in_ready  = adv;
    assign out_valid = vld_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = c_q[LAST];

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        localparam int LO = s * SEG;
        localparam int HI = ((s + 1) * SEG > WIDTH) ? WIDTH : (s + 1) * SEG;

        logic [LW-1:0]    src_a;
        logic [LW-1:0]    src_b;
        logic [LW-1:0]    src_sum;
        logic [LANES-1:0] src_c;
        logic             src_v;
        logic [LW-1:0]    nxt_sum;
        logic [LANES-1:0] nxt_c;

        if (s == 0) begin : g_src_in
            // Stage 0 sees the ports; subtraction is a + ~b + 1 via carry-in.
            always_comb begin
                src_a   = a;
                src_b   = sub ? ~b : b;
                src_sum = '0;
                src_c   = sub ? {LANES{1'b1}} : cin;
                src_v   = in_valid;
            end
        end else begin : g_src_prev
            // Later stages continue from the previous stage's registers.
            always_comb begin
                src_a   = a_q[s-1];
                src_b   = b_q[s-1];
                src_sum = sum_q[s-1];
                src_c   = c_q[s-1];
                src_v   = vld_q[s-1];
            end
        end

        // Ripple this stage's segment [LO, HI) of every lane; other bits pass through.
        always_comb begin
            logic carry;
            nxt_sum = src_sum;
            nxt_c   = src_c;
            carry   = 1'b0;
            for (int k = 0; k < LANES; k++) begin
                carry = src_c[k];
                for (int i = 0; i < WIDTH; i++) begin
                    if ((i >= LO) && (i < HI)) begin
                        nxt_sum[k*WIDTH+i] = src_a[k*WIDTH+i] ^ src_b[k*WIDTH+i] ^ carry;
                        carry = (src_a[k*WIDTH+i] & src_b[k*WIDTH+i]) |
                                (carry & (src_a[k*WIDTH+i] ^ src_b[k*WIDTH+i]));
                    end else begin
                        nxt_sum[k*WIDTH+i] = src_sum[k*WIDTH+i];
                    end
                end
                nxt_c[k] = carry;
            end
        end

        // Stage register: cleared on reset, shifts on adv, holds otherwise.
        always_ff @(posedge clk) begin
            if (rst) begin
                vld_q[s] <= 1'b0;
                a_q[s]   <= '0;
                b_q[s]   <= '0;
                sum_q[s] <= '0;
                c_q[s]   <= '0;
            end else if (adv) begin
                vld_q[s] <= src_v;
                a_q[s]   <= src_a;
                b_q[s]   <= src_b;
                sum_q[s] <= nxt_sum;
                c_q[s]   <= nxt_c;
            end
        end
    end

`ifdef MLPA_OVF_STICKY_EN
    logic [LANES-1:0] ovf_raw;
    logic [LANES-1:0] ovf_sticky_q;

    // Signed overflow: operand signs agree and the result sign differs.
    always_comb begin
        ovf_raw = '0;
        for (int k = 0; k < LANES; k++) begin
            ovf_raw[k] = (a_q[LAST][k*WIDTH+WIDTH-1] == b_q[LAST][k*WIDTH+WIDTH-1]) &&
                         (sum_q[LAST][k*WIDTH+WIDTH-1] != a_q[LAST][k*WIDTH+WIDTH-1]);
        end
    end

    assign ovf        = vld_q[LAST] ? ovf_raw : {LANES{1'b0}};
    assign ovf_sticky = ovf_sticky_q;

    // Sticky flags: set on output transfer with ovf, clear on ovf_clr; set wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_sticky_q <= '0;
        end else begin
            ovf_sticky_q <= (ovf_clr ? {LANES{1'b0}} : ovf_sticky_q) |
                            ((vld_q[LAST] && out_ready) ? ovf_raw : {LANES{1'b0}});
        end
    end
`endif

endmodule

// File: tb/tb_multi_lane_pipelined_adder.sv
// -----------------------------------------------------------------------------
// Self-checking bench for multi_lane_pipelined_adder (WIDTH=8, LANES=4, SEG=4).
// Directed vectors with hand-computed results, a short mixed add/sub stream
// with a mid-stream stall, and reset while data is in flight.
// -----------------------------------------------------------------------------
module tb_multi_lane_pipelined_adder;

    localparam int WIDTH = 8;
    localparam int LANES = 4;
    localparam int SEG   = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  cin;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic [3:0]  cout;
`ifdef MLPA_OVF_STICKY_EN
    logic        ovf_clr;
    logic [3:0]  ovf;
    logic [3:0]  ovf_sticky;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    multi_lane_pipelined_adder #(.WIDTH(WIDTH), .LANES(LANES), .SEG(SEG)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef MLPA_OVF_STICKY_EN
        ,
        .ovf_clr   (ovf_clr),
        .ovf       (ovf),
        .ovf_sticky(ovf_sticky)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < n; i++) step();
    endtask

    // One transfer into an empty pipe; result expected two edges later.
    task automatic run_one(input string tag, input logic [31:0] ta, input logic [31:0] tb,
                           input logic [3:0] tc, input logic ts,
                           input logic [31:0] es, input logic [3:0] ec);
        a = ta; b = tb; cin = tc; sub = ts;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        check_val({tag, "_early"}, {63'd0, out_valid}, 64'd0);
        step();
        check_val({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
        check_val({tag, "_sum"}, {32'd0, sum}, {32'd0, es});
        check_val({tag, "_cout"}, {60'd0, cout}, {60'd0, ec});
    endtask

    // Reference for one lane: 9-bit {carry, sum}.
    function automatic logic [8:0] lane_ref(input logic [7:0] x, input logic [7:0] y,
                                            input logic c, input logic s);
        logic [8:0] r;
        if (s) r = {1'b0, x} + {1'b0, ~y} + 9'd1;
        else   r = {1'b0, x} + {1'b0, y} + {8'd0, c};
        return r;
    endfunction

    logic [31:0] st_a   [10];
    logic [31:0] st_b   [10];
    logic [3:0]  st_c   [10];
    logic        st_s   [10];
    logic [35:0] st_exp [10];

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int recv;
        int cyc;
        logic        stall_seen;
        logic [35:0] snap;

        rst = 1'b1; in_valid = 1'b0; sub = 1'b0; a = '0; b = '0; cin = '0;
        out_ready = 1'b0;
`ifdef MLPA_OVF_STICKY_EN
        ovf_clr = 1'b0;
`endif
        step();
        step();
        check_val("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check_val("rst_sum", {32'd0, sum}, 64'd0);
        check_val("rst_cout", {60'd0, cout}, 64'd0);
        rst = 1'b0;
        #1;
        check_val("rst_in_ready", {63'd0, in_ready}, 64'd1);

        // Basic add, no carries.
        run_one("add_basic", 32'h0102_0304, 32'h1020_3040, 4'h0, 1'b0, 32'h1122_3344, 4'h0);
        // Lane 0 carry across segment boundary; lane 3 all ones plus cin.
        run_one("add_carry", 32'hFF00_000F, 32'hFF00_0001, 4'b1001, 1'b0, 32'hFF00_0011, 4'b1000);
        // Subtract with borrow, cin ignored.
        run_one("sub_borrow", 32'h0505_0505, 32'h0707_0707, 4'hF, 1'b0 | 1'b1, 32'hFEFE_FEFE, 4'h0);
        // Subtract equal operands.
        run_one("sub_equal", 32'h3333_3333, 32'h3333_3333, 4'h0, 1'b1, 32'h0000_0000, 4'hF);
        // Mixed lanes: 80+01, FF+01 (wrap), 7F+01, 01+01.
        run_one("add_mixed", 32'h80FF_7F01, 32'h0101_0101, 4'h0, 1'b0, 32'h8100_8002, 4'b0100);

`ifdef MLPA_OVF_STICKY_EN
        run_one("ovf_pos", 32'h0000_007F, 32'h0000_0001, 4'h0, 1'b0, 32'h0000_0080, 4'h0);
        check_val("ovf_flag", {60'd0, ovf}, 64'd1);
        step();
        check_val("ovf_sticky_set", {60'd0, ovf_sticky}, 64'd1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        check_val("ovf_sticky_clr", {60'd0, ovf_sticky}, 64'd0);
        run_one("ovf_none", 32'h0000_0001, 32'h0000_0001, 4'h0, 1'b0, 32'h0000_0002, 4'h0);
        check_val("ovf_clear", {60'd0, ovf}, 64'd0);
`endif

        idle(3);

        // Stream of 10 mixed add/sub sets with a 3-cycle output stall.
        for (int i = 0; i < 10; i++) begin
            st_a[i] = 32'h1F2E_3D4C + i * 32'h1357_9BDF;
            st_b[i] = 32'hF0E1_D2C3 ^ (i * 32'h0102_0304);
            st_c[i] = 4'(i);
            st_s[i] = i[0];
            for (int k = 0; k < 4; k++) begin
                logic [8:0] r;
                r = lane_ref(st_a[i][k*8 +: 8], st_b[i][k*8 +: 8], st_c[i][k], st_s[i]);
                st_exp[i][k*8 +: 8] = r[7:0];
                st_exp[i][32 + k]   = r[8];
            end
        end
        sent = 0; recv = 0; cyc = 0; stall_seen = 1'b0; snap = '0;
        while (recv < 10 && cyc < 60) begin
            out_ready = !(cyc >= 5 && cyc <= 7);
            if (sent < 10) begin
                in_valid = 1'b1;
                a = st_a[sent]; b = st_b[sent]; cin = st_c[sent]; sub = st_s[sent];
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (cyc >= 5 && cyc <= 7) begin
                check_val($sformatf("stall_valid_%0d", cyc), {63'd0, out_valid}, 64'd1);
                check_val($sformatf("stall_in_ready_%0d", cyc), {63'd0, in_ready}, 64'd0);
                if (stall_seen) begin
                    check_val($sformatf("stall_hold_%0d", cyc), {28'd0, cout, sum}, {28'd0, snap});
                end
                snap = {cout, sum};
                stall_seen = 1'b1;
            end
            if (out_valid && out_ready) begin
                check_val($sformatf("stream_%0d", recv), {28'd0, cout, sum}, {28'd0, st_exp[recv]});
                recv++;
            end
            if (in_valid && in_ready) sent++;
            step();
            cyc++;
        end
        check_val("stream_count", 64'(recv), 64'd10);
        check_val("stream_sent", 64'(sent), 64'd10);

        idle(3);

        // Reset with two sets in flight.
        out_ready = 1'b0;
        a = 32'h1111_1111; b = 32'h2222_2222; cin = 4'h0; sub = 1'b0;
        in_valid = 1'b1;
        step();
        a = 32'h4444_4444; b = 32'h1111_1111;
        step();
        check_val("inflight_valid", {63'd0, out_valid}, 64'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("rst_flush_valid", {63'd0, out_valid}, 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_val($sformatf("rst_flush_stay_%0d", i), {63'd0, out_valid}, 64'd0);
        end
        run_one("after_rst", 32'h0A0B_0C0D, 32'h0101_0101, 4'h0, 1'b0, 32'h0B0C_0D0E, 4'h0);

        idle(2);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
